// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DMA_ACC = 2'd2,
        RESP    = 2'd3
    } arbStateT;

    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_DMA = 1'b1
    } grantT;

    localparam int          TIMEOUT_DEFAULT = 255;
    localparam logic [31:0] ERR_DATA        = 32'hDEADBEEF;

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin picker: on a tie the port not served last wins.
module arb_rr2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       lastGrant,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        grant = 2'b00;
        if (req0 && req1) begin
            grant = lastGrant ? 2'b01 : 2'b10;
        end else begin
            grant = {req1, req0};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a read-only DMA port onto one memory, with a
// per-access timeout that aborts to an error response.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic              cpu_half,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ok,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ok,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_half,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              timeout_err
);

    arbStateT   state, nextState;
    grantT      lastGrant;
    logic [1:0] grant;
    logic [7:0] timeoutCnt;
    logic       cpuReq, inAcc, accDone, accAbort;

    assign cpuReq   = cpu_read | cpu_write;
    assign inAcc    = (state == CPU_ACC) || (state == DMA_ACC);
    assign accDone  = inAcc && mem_done;
    assign accAbort = inAcc && !mem_done && (timeoutCnt == 8'(TIMEOUT - 1));

    arb_rr2 u_rr (
        .req0      (cpuReq),
        .req1      (dma_req),
        .lastGrant (lastGrant == GRANT_DMA),
        .grant     (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is assigned with <= so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (grant[0])      nextState = CPU_ACC;
                else if (grant[1]) nextState = DMA_ACC;
            end
            CPU_ACC, DMA_ACC: begin
                if (accDone || accAbort) nextState = RESP;
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        cpu_ok = (state == RESP) && (lastGrant == GRANT_CPU);
        dma_ok = (state == RESP) && (lastGrant == GRANT_DMA);
    end

    // Memory-side strobes, the latched access and the response data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant   <= GRANT_DMA;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_half    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            timeoutCnt  <= '0;
            cpu_rdata   <= '0;
            dma_rdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            mem_en     <= (nextState == CPU_ACC) || (nextState == DMA_ACC);
            timeoutCnt <= inAcc ? timeoutCnt + 8'd1 : 8'd0;
            if (accAbort) timeout_err <= 1'b1;

            if (state == IDLE && grant[0]) begin
                lastGrant <= GRANT_CPU;
                mem_we    <= cpu_write;
                mem_half  <= cpu_half;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (state == IDLE && grant[1]) begin
                lastGrant <= GRANT_DMA;
                mem_we    <= 1'b0;
                mem_half  <= 1'b0;
                mem_addr  <= dma_addr;
                mem_wdata <= '0;
            end

            if (accDone || accAbort) begin
                if (state == CPU_ACC) cpu_rdata <= accDone ? mem_rdata : DATA_W'(ERR_DATA);
                else                  dma_rdata <= accDone ? mem_rdata : DATA_W'(ERR_DATA);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_read, cpu_write, cpu_half;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ok;
    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ok;
    logic              mem_en, mem_we, mem_half;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              timeout_err;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(255)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_half    (cpu_half),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ok      (cpu_ok),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .dma_rdata   (dma_rdata),
        .dma_ok      (dma_ok),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_half    (mem_half),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge; drive and sample there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_half = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; dma_req = 1'b0; dma_addr = '0;
        mem_rdata = '0; mem_done = 1'b0;
        tick();
        tick();

        check("rst_mem_en",      mem_en,      1'b0);
        check("rst_cpu_ok",      cpu_ok,      1'b0);
        check("rst_dma_ok",      dma_ok,      1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_mem_addr",    mem_addr,    15'h0);
        check("rst_cpu_rdata",   cpu_rdata,   32'h0);
        rst = 1'b0;
        tick();

        // CPU read 0x0010, mem_done three cycles after the request.
        cpu_read = 1'b1; cpu_addr = 15'h0010;                  // cycle 0
        tick();                                                 // cycle 1
        check("rd_mem_en",   mem_en,   1'b1);
        check("rd_mem_we",   mem_we,   1'b0);
        check("rd_mem_addr", mem_addr, 15'h0010);
        tick();                                                 // cycle 2
        cpu_addr = 15'h7FFF;
        tick();                                                 // cycle 3
        check("rd_addr_held", mem_addr, 15'h0010);
        check("rd_no_ok_yet", cpu_ok,   1'b0);
        mem_done = 1'b1; mem_rdata = 32'h12345678;
        tick();                                                 // cycle 4: RESP
        mem_done = 1'b0; mem_rdata = '0;
        check("rd_cpu_ok",    cpu_ok,    1'b1);
        check("rd_dma_ok",    dma_ok,    1'b0);
        check("rd_cpu_rdata", cpu_rdata, 32'h12345678);
        check("rd_mem_en_off", mem_en,   1'b0);
        tick();                                                 // cycle 5: IDLE
        cpu_read = 1'b0;
        check("rd_ok_pulse", cpu_ok, 1'b0);
        mem_done = 1'b1; mem_rdata = 32'h55555555;
        tick();
        mem_done = 1'b0;
        check("idle_done_ignored_ok",    cpu_ok,    1'b0);
        check("idle_done_ignored_rdata", cpu_rdata, 32'h12345678);
        check("idle_done_ignored_en",    mem_en,    1'b0);

        // Halfword write with read also high: treated as a write.
        cpu_write = 1'b1; cpu_read = 1'b1; cpu_half = 1'b1;
        cpu_addr = 15'h0020; cpu_wdata = 32'h0000ABCD;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("wr_mem_en",    mem_en,    1'b1);
            check("wr_mem_we",    mem_we,    1'b1);
            check("wr_mem_half",  mem_half,  1'b1);
            check("wr_mem_addr",  mem_addr,  15'h0020);
            check("wr_mem_wdata", mem_wdata, 32'h0000ABCD);
        end
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        check("wr_cpu_ok", cpu_ok, 1'b1);
        check("wr_mem_en_off", mem_en, 1'b0);
        tick();
        cpu_write = 1'b0; cpu_read = 1'b0; cpu_half = 1'b0;

        // Simultaneous requests out of reset alternate CPU, DMA, CPU, DMA.
        applyReset();
        cpu_read = 1'b1; cpu_addr = 15'h0100;
        dma_req  = 1'b1; dma_addr = 15'h0200;
        for (int i = 0; i < 4; i++) begin
            logic isDma;
            isDma = (i % 2) == 1;
            tick();                                             // ACC
            check("rr_mem_en",   mem_en,   1'b1);
            check("rr_mem_addr", mem_addr, isDma ? 15'h0200 : 15'h0100);
            if (isDma) begin
                check("rr_dma_we",   mem_we,   1'b0);
                check("rr_dma_half", mem_half, 1'b0);
            end
            mem_done = 1'b1; mem_rdata = 32'hA0000000 + 32'(i);
            tick();                                             // RESP
            mem_done = 1'b0;
            check("rr_cpu_ok", cpu_ok, !isDma);
            check("rr_dma_ok", dma_ok, isDma);
            if (isDma) check("rr_dma_rdata", dma_rdata, 32'hA0000000 + 32'(i));
            else       check("rr_cpu_rdata", cpu_rdata, 32'hA0000000 + 32'(i));
            if (i == 3) begin
                cpu_read = 1'b0; dma_req = 1'b0;
            end
            tick();                                             // IDLE
            check("rr_idle_en", mem_en, 1'b0);
        end

        // DMA read that never completes aborts after 255 access cycles.
        dma_req = 1'b1; dma_addr = 15'h0300;
        tick();                                                 // first ACC cycle
        for (int c = 0; c < 254; c++) tick();                   // 255th ACC cycle
        check("to_last_acc_en",  mem_en,      1'b1);
        check("to_last_acc_ok",  dma_ok,      1'b0);
        check("to_err_not_yet",  timeout_err, 1'b0);
        tick();                                                 // RESP
        check("to_dma_ok",    dma_ok,      1'b1);
        check("to_dma_rdata", dma_rdata,   32'hDEADBEEF);
        check("to_err_set",   timeout_err, 1'b1);
        check("to_mem_en",    mem_en,      1'b0);
        tick();
        dma_req = 1'b0;
        check("to_ok_pulse", dma_ok, 1'b0);
        cpu_read = 1'b1; cpu_addr = 15'h0011;
        tick();
        mem_done = 1'b1; mem_rdata = 32'h0BADF00D;
        tick();
        mem_done = 1'b0;
        check("to_err_sticky", timeout_err, 1'b1);
        check("to_next_cpu_rdata", cpu_rdata, 32'h0BADF00D);
        tick();
        cpu_read = 1'b0;

        // Reset mid-access: mem_en drops at once, no ok, next access normal.
        applyReset();
        check("rst_clears_err", timeout_err, 1'b0);
        cpu_read = 1'b1; cpu_addr = 15'h0040;
        tick();
        check("ra_mem_en", mem_en, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("ra_mem_en_async", mem_en,    1'b0);
        check("ra_no_cpu_ok",    cpu_ok,    1'b0);
        check("ra_rdata_zero",   cpu_rdata, 32'h0);
        tick();
        check("ra_no_cpu_ok_2", cpu_ok, 1'b0);
        rst = 1'b0;
        tick();
        check("ra_new_en",   mem_en,   1'b1);
        check("ra_new_addr", mem_addr, 15'h0040);
        mem_done = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_done = 1'b0;
        check("ra_new_ok",    cpu_ok,    1'b1);
        check("ra_new_rdata", cpu_rdata, 32'hCAFEF00D);
        tick();
        cpu_read = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
